ofdm_frame_sequencer: RTL and testbench
=======================================

# ofdm_frame_sequencer

Controller that sequences reads from the QAM symbol ROM and assembles them into OFDM frames for the IFFT input stage. Each frame holds SYMS_PER_FRAME OFDM symbols of NUM_CARRIERS slots; slots outside the data band are emitted as null carriers without a ROM read. The block owns the ROM address and wraps it at ROM_DEPTH, handles the 1-cycle ROM read latency, and honours downstream valid/ready backpressure without losing or duplicating symbols.

## Interface

- ADDR_WIDTH, 11, ROM address width
- DATA_WIDTH, 8, ROM word / output width
- ROM_DEPTH, 1648, ROM entries; address wraps ROM_DEPTH-1 -> 0
- NUM_CARRIERS, 64, slots per OFDM symbol
- GUARD_LO, 8, leading null slots per symbol
- DATA_PER_SYM, 48, data slots following the leading guard (GUARD_LO+DATA_PER_SYM <= NUM_CARRIERS)
- SYMS_PER_FRAME, 14, OFDM symbols per frame

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a frame
- abort  in  1  one-cycle pulse, cancels the frame in progress
- rom_addr  out  ADDR_WIDTH  ROM read address
- rom_en  out  1  ROM read enable
- rom_data  in  DATA_WIDTH  ROM word, valid the cycle after rom_en
- m_data  out  DATA_WIDTH  slot value; 0 on null slots
- m_null  out  1  slot is a null carrier
- m_sos  out  1  first slot of an OFDM symbol
- m_sof  out  1  first slot of the frame
- m_eof  out  1  last slot of the frame
- m_valid  out  1  output slot valid
- m_ready  in  1  downstream accepts
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last slot of the frame is accepted

## Operation

- Reset: all outputs 0, rom_addr 0, state IDLE, slot/symbol counters 0, buffer empty.
- States: IDLE -> RUN on start; RUN -> DRAIN when the last slot of the last symbol is issued; DRAIN -> DONE when the buffer is empty and the last slot is accepted; DONE -> IDLE unconditionally (done=1 during DONE). abort in any state -> IDLE next edge.
- busy = 1 in RUN, DRAIN, DONE.
- Issue counters: slot 0..NUM_CARRIERS-1, symbol 0..SYMS_PER_FRAME-1. Data slot: GUARD_LO <= slot < GUARD_LO+DATA_PER_SYM; all others null.
- One slot is issued per cycle in RUN when credit is available. Data slot: rom_en=1, rom_addr advances by 1 on the edge, wrapping ROM_DEPTH-1 -> 0. Null slot: rom_en=0, address unchanged.
- Issued slots pass through a 1-stage tag pipe (null/sos/sof/eof) aligned with ROM latency, then into a 2-entry output FIFO whose head drives m_*. Credit: issue only if FIFO occupancy + in-flight < 2.
- rom_addr persists across frames and across abort; only rst clears it.
- start while busy: ignored. start and abort in the same cycle: abort wins.
- abort: m_valid drops next edge, FIFO and in-flight tag discarded, counters cleared, no done pulse.
- Output stable while m_valid && !m_ready.

## Timing

- start sampled at edge E0 -> rom_en/first issue in cycle after E0 -> rom_data captured at E2 -> m_valid=1 after E2 (2-cycle start-to-valid latency). Null slots have the same latency.
- With m_ready held 1: one slot per cycle, no bubbles, frame takes NUM_CARRIERS*SYMS_PER_FRAME cycles plus 2 latency; done pulses the cycle after the m_eof transfer edge.
- m_ready low: issue stalls within 1 cycle; no slot lost; throughput returns to 1/cycle the cycle after m_ready rises.

## Structure

- Shared package ofdm_pkg: state enum (IDLE, RUN, DRAIN, DONE), slot tag struct {null, sos, sof, eof}, frame geometry constants.
- One sub-module: seq_skid_fifo (2-entry valid/ready FIFO carrying {tag, data}).

## Test plan

- Config NUM_CARRIERS=8, GUARD_LO=2, DATA_PER_SYM=4, SYMS_PER_FRAME=2, ROM word = addr[7:0]; start, m_ready=1 -> 16 slots, pattern N,N,0,1,2,3,N,N,N,N,4,5,6,7,N,N; m_sof on slot 0, m_sos on slots 0 and 8, m_eof on slot 15, done once; rom_addr ends at 8.
- ROM_DEPTH=6, same geometry -> data sequence 0,1,2,3,4,5,0,1; wrap with no skipped or repeated word.
- Random m_ready (50%) over 3 frames -> accepted sequence identical to the m_ready=1 run; m_data/m_null stable while stalled.
- abort mid-symbol 1 -> m_valid 0 next cycle, no done; next start resumes data at the following ROM address with m_sof on first slot.
- start during busy -> ignored, single frame; rst asserted mid-frame -> all outputs 0 immediately, rom_addr 0.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared types and default frame geometry for the OFDM frame sequencer.
package ofdm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

    typedef struct packed {
        logic is_null;
        logic sos;
        logic sof;
        logic eof;
    } slot_tag_t;

    localparam int TAG_W              = $bits(slot_tag_t);
    localparam int DEF_ADDR_WIDTH     = 11;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ROM_DEPTH      = 1648;
    localparam int DEF_NUM_CARRIERS   = 64;
    localparam int DEF_GUARD_LO       = 8;
    localparam int DEF_DATA_PER_SYM   = 48;
    localparam int DEF_SYMS_PER_FRAME = 14;

    function automatic logic is_data_slot(input int slot, input int guard_lo, input int data_per_sym);
        return (slot >= guard_lo) && (slot < guard_lo + data_per_sym);
    endfunction

endpackage

// File: rtl/ofdm_frame_sequencer_if.sv
// Slot stream from the frame sequencer to the IFFT input stage.
interface ofdm_frame_sequencer_if import ofdm_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_null;
    logic                  m_sos;
    logic                  m_sof;
    logic                  m_eof;
    logic                  m_valid;
    logic                  m_ready;

    modport master (output m_data, m_null, m_sos, m_sof, m_eof, m_valid, input m_ready);
    modport slave  (input m_data, m_null, m_sos, m_sof, m_eof, m_valid, output m_ready);
endinterface

// File: rtl/seq_skid_fifo.sv
// Two-entry FIFO; the writer must only push when space is known to exist (see count_o).
module seq_skid_fifo #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         push;
    logic         pop;

    assign push        = in_valid_i && (cnt_q != 2'd2);
    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    // Storage is not reset: every consumer gates it with out_valid_o.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule

// File: rtl/ofdm_frame_sequencer.sv
// Walks slot/symbol counters, reads QAM words from ROM for data slots, and streams
// tagged slots through a one-deep ROM-latency tag pipe into a 2-entry output FIFO.
module ofdm_frame_sequencer import ofdm_pkg::*; #(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ROM_DEPTH      = DEF_ROM_DEPTH,
    parameter int NUM_CARRIERS   = DEF_NUM_CARRIERS,
    parameter int GUARD_LO       = DEF_GUARD_LO,
    parameter int DATA_PER_SYM   = DEF_DATA_PER_SYM,
    parameter int SYMS_PER_FRAME = DEF_SYMS_PER_FRAME
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    ofdm_frame_sequencer_if.master m,
    output logic                  busy,
    output logic                  done
);
    localparam int SLOT_W = $clog2(NUM_CARRIERS) + 1;
    localparam int SYM_W  = $clog2(SYMS_PER_FRAME) + 1;

    seq_state_t            state_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [SYM_W-1:0]      sym_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  infl_q;
    slot_tag_t             tag_q;
    slot_tag_t             tag_d;

    logic                  is_data;
    logic                  last_in_sym;
    logic                  last_sym;
    logic                  credit;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occ_sum;
    logic                  head_valid;
    logic [1:0]            fifo_count;
    slot_tag_t             head_tag;
    logic [DATA_WIDTH-1:0] head_word;

    assign is_data     = is_data_slot(int'(slot_q), GUARD_LO, DATA_PER_SYM);
    assign last_in_sym = (slot_q == SLOT_W'(NUM_CARRIERS - 1));
    assign last_sym    = (sym_q == SYM_W'(SYMS_PER_FRAME - 1));
    assign pop         = head_valid && m.m_ready;

    // A slot popped this cycle frees its entry in time for the slot issued now.
    assign occ_sum = 3'(fifo_count) + 3'(infl_q);
    assign credit  = occ_sum < (3'd2 + 3'(pop));
    assign issue   = (state_q == RUN) && credit && !abort;

    assign rom_en   = issue && is_data;
    assign rom_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    always_comb begin
        tag_d         = '0;
        tag_d.is_null = !is_data;
        tag_d.sos     = (slot_q == '0);
        tag_d.sof     = (slot_q == '0) && (sym_q == '0);
        tag_d.eof     = last_in_sym && last_sym;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            slot_q  <= '0;
            sym_q   <= '0;
            addr_q  <= '0;
            infl_q  <= 1'b0;
        end else begin
            if (rom_en) addr_q <= (addr_q == ADDR_WIDTH'(ROM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
            infl_q <= issue;
            if (abort) begin
                state_q <= IDLE;
                slot_q  <= '0;
                sym_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q <= RUN;
                        slot_q  <= '0;
                        sym_q   <= '0;
                    end
                    RUN: if (issue) begin
                        if (last_in_sym) begin
                            slot_q <= '0;
                            if (last_sym) begin
                                sym_q   <= '0;
                                state_q <= DRAIN;
                            end else begin
                                sym_q <= sym_q + SYM_W'(1);
                            end
                        end else begin
                            slot_q <= slot_q + SLOT_W'(1);
                        end
                    end
                    DRAIN: if (pop && head_tag.eof) state_q <= DONE;
                    DONE:  state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Tag pipe stage: lines up with the ROM word arriving one cycle after rom_en.
    always_ff @(posedge clk) begin
        if (issue) tag_q <= tag_d;
    end

    seq_skid_fifo #(.W(TAG_W + DATA_WIDTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (abort),
        .in_valid_i  (infl_q),
        .in_data_i   ({tag_q, (tag_q.is_null ? {DATA_WIDTH{1'b0}} : rom_data)}),
        .out_valid_o (head_valid),
        .out_ready_i (m.m_ready),
        .out_data_o  ({head_tag, head_word}),
        .count_o     (fifo_count)
    );

    assign m.m_valid = head_valid;
    assign m.m_data  = head_valid ? head_word : '0;
    assign m.m_null  = head_valid && head_tag.is_null;
    assign m.m_sos   = head_valid && head_tag.sos;
    assign m.m_sof   = head_valid && head_tag.sof;
    assign m.m_eof   = head_valid && head_tag.eof;
endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// Directed bench: 8-slot/2-symbol frames, ROM word = address, plus a 6-deep ROM copy for wrap.
module tb_ofdm_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [10:0] addr_a, addr_b;
    logic        en_a, en_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  rd_a, rd_b;

    ofdm_frame_sequencer_if #(.DATA_WIDTH(8)) sa ();
    ofdm_frame_sequencer_if #(.DATA_WIDTH(8)) sb ();

    always #5 clk = ~clk;
    assign sb.m_ready = sa.m_ready;

    ofdm_frame_sequencer #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .ROM_DEPTH(1648), .NUM_CARRIERS(8),
                           .GUARD_LO(2), .DATA_PER_SYM(4), .SYMS_PER_FRAME(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(addr_a), .rom_en(en_a),
        .rom_data(rd_a), .m(sa), .busy(busy_a), .done(done_a));

    ofdm_frame_sequencer #(.ADDR_WIDTH(11), .DATA_WIDTH(8), .ROM_DEPTH(6), .NUM_CARRIERS(8),
                           .GUARD_LO(2), .DATA_PER_SYM(4), .SYMS_PER_FRAME(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rom_addr(addr_b), .rom_en(en_b),
        .rom_data(rd_b), .m(sb), .busy(busy_b), .done(done_b));

    always_ff @(posedge clk) begin
        if (en_a) rd_a <= addr_a[7:0];
        if (en_b) rd_b <= addr_b[7:0];
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int exp_off[16] = '{-1, -1, 0, 1, 2, 3, -1, -1, -1, -1, 4, 5, 6, 7, -1, -1};
    int exp_b[8]    = '{0, 1, 2, 3, 4, 5, 0, 1};

    logic [11:0] acc[$];
    logic [7:0]  accb[$];
    int first_valid, done_cyc, ndone, stall_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input bit rnd, input int abort_cyc, input int restart_cyc,
                             input bit take_b, input int budget);
        logic [11:0] cur, prev;
        bit prev_stall;
        acc.delete(); accb.delete();
        first_valid = -1; done_cyc = -1; ndone = 0; stall_err = 0;
        prev_stall = 1'b0; prev = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            start = (cyc == restart_cyc);
            cur = {sa.m_null, sa.m_sos, sa.m_sof, sa.m_eof, sa.m_data};
            if (first_valid < 0 && sa.m_valid) first_valid = cyc;
            if (done_a) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_stall && (!sa.m_valid || cur !== prev)) stall_err++;
            if (cyc == abort_cyc) begin
                abort = 1'b1;
                break;
            end
            sa.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sa.m_valid && sa.m_ready) acc.push_back(cur);
            if (take_b && sb.m_valid && sb.m_ready && !sb.m_null) accb.push_back(sb.m_data);
            prev_stall = sa.m_valid && !sa.m_ready;
            prev = cur;
            if (done_cyc >= 0) break;
            @(negedge clk);
        end
        start = 1'b0;
        sa.m_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [11:0] obs, exp;
        logic nul;
        chk({tag, "_count"}, acc.size(), 16);
        for (int i = 0; i < 16; i++) begin
            nul = (exp_off[i] < 0);
            exp = {nul, (i == 0 || i == 8), (i == 0), (i == 15), (nul ? 8'd0 : 8'(base + exp_off[i]))};
            obs = (i < acc.size()) ? acc[i] : 'x;
            chk($sformatf("%s_slot%0d", tag, i), obs, exp);
        end
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sa.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", sa.m_valid, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_rom_en", en_a, 0);
        chk("rst_rom_addr", addr_a, 0);
        rst = 1'b0;

        run_frame(1'b0, 0, 0, 1'b1, 60);
        chk("f1_latency", first_valid, 3);
        chk("f1_done_cycle", done_cyc, 19);
        chk("f1_done_count", ndone, 1);
        check_frame("f1", 0);
        chk("f1_rom_addr", addr_a, 8);
        chk("wrap_count", accb.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("wrap_data%0d", i), (i < accb.size()) ? accb[i] : 'x, exp_b[i]);
        chk("wrap_rom_addr", addr_b, 2);
        @(negedge clk);
        chk("f1_done_once", done_a, 0);
        chk("f1_idle", busy_a, 0);

        for (int f = 0; f < 3; f++) begin
            run_frame(1'b1, 0, 0, 1'b0, 300);
            chk($sformatf("rnd%0d_done_count", f), ndone, 1);
            chk($sformatf("rnd%0d_stall_stable", f), stall_err, 0);
            check_frame($sformatf("rnd%0d", f), 8 + 8 * f);
            @(negedge clk);
            chk($sformatf("rnd%0d_done_once", f), done_a, 0);
        end
        chk("rnd_rom_addr", addr_a, 32);

        run_frame(1'b0, 12, 0, 1'b0, 60);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", sa.m_valid, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_rom_addr", addr_a, 37);
        dcnt = (done_a === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done_a === 1'b1) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        run_frame(1'b0, 0, 5, 1'b0, 60);
        chk("resume_done_count", ndone, 1);
        check_frame("resume", 37);
        @(negedge clk);
        chk("resume_idle", busy_a, 0);
        chk("resume_rom_addr", addr_a, 45);

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        chk("prereset_valid", sa.m_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stream", {sa.m_valid, sa.m_null, sa.m_sos, sa.m_sof, sa.m_eof, sa.m_data}, 0);
        chk("midrst_ctrl", {busy_a, done_a, en_a}, 0);
        chk("midrst_rom_addr", addr_a, 0);
        @(negedge clk);
        rst = 1'b0;

        run_frame(1'b0, 0, 0, 1'b0, 60);
        chk("post_rst_done_count", ndone, 1);
        check_frame("post_rst", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
